// File: rtl/ecc_psm_arbiter_if.sv
// ecc_psm_arbiter_if: requester-side request/response bundle for ecc_psm_arbiter
interface ecc_psm_arbiter_if #(parameter int NREQ = 4);
   logic [NREQ-1:0]     req_valid;
   logic [NREQ-1:0]     req_ready;
   logic [NREQ*256-1:0] req_px;
   logic [NREQ*256-1:0] req_py;
   logic [NREQ*256-1:0] req_m;
   logic [NREQ*256-1:0] req_d;
   logic [NREQ-1:0]     resp_valid;
   logic [NREQ-1:0]     resp_ack;
   logic [255:0]        resp_rx;
   logic [255:0]        resp_ry;
   logic                resp_err;
   modport master (
      output req_valid, req_px, req_py, req_m, req_d, resp_ack,
      input  req_ready, resp_valid, resp_rx, resp_ry, resp_err
   );
   modport slave (
      input  req_valid, req_px, req_py, req_m, req_d, resp_ack,
      output req_ready, resp_valid, resp_rx, resp_ry, resp_err
   );
endinterface

// File: rtl/ecc_psm_arbiter.sv
// ecc_psm_arbiter: round-robin sharing of one point-scalar-multiply core; optional watchdog via ECC_ARB_TIMEOUT_EN
module ecc_psm_arbiter #(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 1 << 20
) (
   input  logic                 clk,
   input  logic                 rst,
   ecc_psm_arbiter_if.slave     bus,
   output logic                 core_start,
   output logic [255:0]         core_px,
   output logic [255:0]         core_py,
   output logic [255:0]         core_m,
   output logic [255:0]         core_d,
   input  logic [255:0]         core_rx,
   input  logic [255:0]         core_ry,
   input  logic                 core_ready,
   output logic                 busy
);
   localparam int IW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;
   state_t          state, state_next;
   logic [IW-1:0]   owner, last_grant, grant_idx, idx;
   logic [NREQ-1:0] grant;
   logic            any, ready_q, rise, tmo, fin, accept;
   // round-robin search starting just after the previous winner; the nearest valid requester wins
   always_comb begin
      grant_idx = '0;
      idx       = '0;
      any       = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last_grant) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            grant_idx = idx;
            any       = 1'b1;
         end
      end
      grant = any ? (NREQ'(1) << grant_idx) : '0;
   end
   assign accept         = (state == IDLE) && any;
   assign rise           = core_ready && !ready_q;
   assign fin            = (state == RUN) && (rise || tmo);
   assign bus.req_ready  = (state == IDLE) ? grant : '0;
   assign bus.resp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
   assign core_start     = (state == RUN);
   assign busy           = (state != IDLE);
`ifdef ECC_ARB_TIMEOUT_EN
   logic [31:0] tmo_cnt;
   // watchdog counts RUN cycles and restarts from zero on every entry to RUN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_cnt <= '0;
      else     tmo_cnt <= (state == RUN) ? tmo_cnt + 32'd1 : '0;
   end
   assign tmo = (state == RUN) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
   assign tmo = 1'b0;
`endif
   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end
   // next state: accept, wait for completion, wait for owner ack, wait for core_ready to clear
   always_comb begin
      state_next = state;
      if (accept) state_next = RUN;
      if (fin) state_next = RESP;
      if (state == RESP && bus.resp_ack[owner]) state_next = DRAIN;
      if (state == DRAIN && !core_ready) state_next = IDLE;
   end
   // operand capture on acceptance, result capture on completion or watchdog expiry
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_px      <= '0;
         core_py      <= '0;
         core_m       <= '0;
         core_d       <= '0;
         owner        <= '0;
         last_grant   <= IW'(NREQ - 1);
         ready_q      <= 1'b0;
         bus.resp_rx  <= '0;
         bus.resp_ry  <= '0;
         bus.resp_err <= 1'b0;
      end else begin
         ready_q <= core_ready;
         if (accept) begin
            core_px    <= bus.req_px[256*grant_idx +: 256];
            core_py    <= bus.req_py[256*grant_idx +: 256];
            core_m     <= bus.req_m[256*grant_idx +: 256];
            core_d     <= bus.req_d[256*grant_idx +: 256];
            owner      <= grant_idx;
            last_grant <= grant_idx;
         end
         if (fin) begin
            bus.resp_rx  <= rise ? core_rx : '0;
            bus.resp_ry  <= rise ? core_ry : '0;
            bus.resp_err <= !rise;
         end
      end
   end
endmodule

// File: tb/tb_ecc_psm_arbiter.sv
// tb_ecc_psm_arbiter: directed bench for ecc_psm_arbiter with a behavioural core model
module tb_ecc_psm_arbiter;
   localparam logic [255:0] GX = 256'h79be667ef9dcbbac55a06295ce870b07029bfcdb2dce28d959f2815b16f81798;
   localparam logic [255:0] GY = 256'h483ada7726a3c4655da4fbfc0e1108a8fd17b448a68554199c47d08ffb10d4b8;
   localparam logic [255:0] P  = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
`ifdef ECC_ARB_TIMEOUT_EN
   localparam int TMO = 100;
`else
   localparam int TMO = 1 << 20;
`endif
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   ecc_psm_arbiter_if #(.NREQ(4)) bus();
   logic         core_start, busy;
   logic         core_ready = 1'b0;
   logic [255:0] core_px, core_py, core_m, core_d;
   logic [255:0] core_rx = '0;
   logic [255:0] core_ry = '0;
   int n_cmp = 0;
   int n_err = 0;
   int lat = 10;
   int stale = 0;
   bit hang = 1'b0;
   int mcnt = 0;
   int hold_cnt = 0;
   ecc_psm_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .core_start(core_start), .core_px(core_px), .core_py(core_py), .core_m(core_m), .core_d(core_d),
      .core_rx(core_rx), .core_ry(core_ry), .core_ready(core_ready), .busy(busy)
   );
   // behavioural core: fixed latency, rx = px + d - 1, ry = py ^ (d - 1), ready lingers 'stale' cycles after start falls
   always @(posedge clk) begin
      if (!core_start) begin
         mcnt <= 0;
         if (core_ready && hold_cnt >= stale) begin
            core_ready <= 1'b0;
            hold_cnt   <= 0;
         end else if (core_ready) hold_cnt <= hold_cnt + 1;
      end else if (!core_ready && !hang) begin
         if (mcnt == lat - 1) begin
            core_ready <= 1'b1;
            core_rx    <= core_px + core_d - 256'd1;
            core_ry    <= core_py ^ (core_d - 256'd1);
         end else mcnt <= mcnt + 1;
      end
   end
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "bench watchdog expired");
   end
   task automatic set_op(input int i, input logic [255:0] d);
      bus.req_px[256*i +: 256] = GX;
      bus.req_py[256*i +: 256] = GY;
      bus.req_m[256*i +: 256]  = P;
      bus.req_d[256*i +: 256]  = d;
   endtask
   task automatic wait_grant(output int cyc);
      cyc = 0;
      #1;
      while (bus.req_ready == 4'b0 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
   endtask
   task automatic wait_resp(output int cyc, output int starts);
      cyc = 0;
      starts = 0;
      while (bus.resp_valid == 4'b0 && cyc < 500) begin
         if (core_start) starts++;
         @(negedge clk);
         cyc++;
      end
   endtask
   task automatic do_ack(input logic [3:0] mask);
      bus.resp_ack = mask;
      @(negedge clk);
      bus.resp_ack = 4'b0;
   endtask
   task automatic test_reset;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_start: got %b want 0", core_start); end
      n_cmp++; if (bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b want 0000", bus.resp_valid); end
      n_cmp++; if (bus.resp_rx !== '0 || bus.resp_ry !== '0 || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL rst_resp: got rx=%h err=%b want 0", bus.resp_rx, bus.resp_err); end
      n_cmp++; if (core_px !== '0 || core_d !== '0) begin n_err++; $display("FAIL rst_core_ops: got px=%h d=%h want 0", core_px, core_d); end
      rst = 1'b0;
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0 || busy !== 1'b0) begin n_err++; $display("FAIL idle_no_req: got ready=%b busy=%b want 0000/0", bus.req_ready, busy); end
   endtask
   task automatic test_single;
      int c, s;
      set_op(0, 256'd1);
      bus.req_valid = 4'b0001;
      wait_grant(c);
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL single_grant: got %b want 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0;
      n_cmp++; if (core_start !== 1'b1 || busy !== 1'b1 || bus.req_ready !== 4'b0) begin n_err++; $display("FAIL single_run: got start=%b busy=%b ready=%b want 1/1/0000", core_start, busy, bus.req_ready); end
      n_cmp++; if (core_px !== GX || core_py !== GY || core_m !== P || core_d !== 256'd1) begin n_err++; $display("FAIL single_ops: got px=%h d=%h", core_px, core_d); end
      wait_resp(c, s);
      n_cmp++; if (s !== 11 || c !== 11) begin n_err++; $display("FAIL single_start_window: got start=%0d resp_at=%0d want 11/11", s, c); end
      n_cmp++; if (bus.resp_valid !== 4'b0001 || core_start !== 1'b0) begin n_err++; $display("FAIL single_resp_valid: got %b start=%b want 0001/0", bus.resp_valid, core_start); end
      n_cmp++; if (bus.resp_rx !== GX || bus.resp_ry !== GY || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL single_result: got rx=%h ry=%h err=%b", bus.resp_rx, bus.resp_ry, bus.resp_err); end
      do_ack(4'b0001);
      n_cmp++; if (bus.resp_valid !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL single_drain: got valid=%b busy=%b want 0000/1", bus.resp_valid, busy); end
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_idle: got busy=%b want 0", busy); end
   endtask
   task automatic test_contention;
      int c, s;
      logic [3:0] exp;
      rst = 1'b1;
      for (int i = 0; i < 4; i++) set_op(i, 256'(i + 1));
      bus.req_valid = 4'b1111;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int op = 0; op < 8; op++) begin
         exp = 4'b0001 << (op % 4);
         wait_grant(c);
         n_cmp++; if (bus.req_ready !== exp) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", op, bus.req_ready, exp); end
         @(negedge clk);
         wait_resp(c, s);
         n_cmp++; if (bus.resp_valid !== exp) begin n_err++; $display("FAIL rr_route[%0d]: got %b want %b", op, bus.resp_valid, exp); end
         n_cmp++; if (bus.resp_rx !== GX + 256'(op % 4) || bus.resp_ry !== (GY ^ 256'(op % 4))) begin n_err++; $display("FAIL rr_result[%0d]: got rx=%h", op, bus.resp_rx); end
         if (op == 7) bus.req_valid = 4'b0;
         do_ack(exp);
      end
      @(negedge clk);
   endtask
   task automatic test_back_to_back;
      int c, s, bad;
      bus.req_valid = 4'b0110;
      wait_grant(c);
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL bp_grant1: got %b want 0010", bus.req_ready); end
      @(negedge clk);
      wait_resp(c, s);
      n_cmp++; if (bus.resp_valid !== 4'b0010) begin n_err++; $display("FAIL bp_resp1: got %b want 0010", bus.resp_valid); end
      bad = 0;
      bus.resp_ack = 4'b0100;
      repeat (50) begin
         @(negedge clk);
         if (bus.resp_valid !== 4'b0010 || bus.req_ready !== 4'b0 || busy !== 1'b1) bad++;
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL bp_hold: got %0d bad cycles want 0", bad); end
      bus.resp_ack = 4'b0010;
      @(negedge clk);
      bus.resp_ack = 4'b0;
      n_cmp++; if (bus.resp_valid !== 4'b0 || bus.req_ready !== 4'b0) begin n_err++; $display("FAIL bp_after_ack: got valid=%b ready=%b want 0000/0000", bus.resp_valid, bus.req_ready); end
      @(negedge clk);
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_grant2: got %b want 0100", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0;
      wait_resp(c, s);
      n_cmp++; if (bus.resp_valid !== 4'b0100 || bus.resp_rx !== GX + 256'd2) begin n_err++; $display("FAIL bp_resp2: got %b rx=%h", bus.resp_valid, bus.resp_rx); end
      do_ack(4'b0100);
      @(negedge clk);
   endtask
   task automatic test_stale_ready;
      int c, s, bad;
      stale = 5;
      set_op(3, 256'd4);
      bus.req_valid = 4'b1000;
      wait_grant(c);
      n_cmp++; if (bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL stale_grant1: got %b want 1000", bus.req_ready); end
      @(negedge clk);
      set_op(3, 256'd2);
      wait_resp(c, s);
      n_cmp++; if (bus.resp_rx !== GX + 256'd3) begin n_err++; $display("FAIL stale_result1: got %h want %h", bus.resp_rx, GX + 256'd3); end
      do_ack(4'b1000);
      bad = 0;
      repeat (5) begin
         if (busy !== 1'b1 || bus.req_ready !== 4'b0) bad++;
         @(negedge clk);
      end
      n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL stale_drain_hold: got %0d bad cycles want 0", bad); end
      wait_grant(c);
      n_cmp++; if (c !== 1 || bus.req_ready !== 4'b1000) begin n_err++; $display("FAIL stale_regrant: got wait=%0d ready=%b want 1/1000", c, bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0;
      wait_resp(c, s);
      n_cmp++; if (s !== 11) begin n_err++; $display("FAIL stale_no_early: got start cycles %0d want 11", s); end
      n_cmp++; if (bus.resp_rx !== GX + 256'd1) begin n_err++; $display("FAIL stale_result2: got %h want %h", bus.resp_rx, GX + 256'd1); end
      do_ack(4'b1000);
      stale = 0;
      repeat (8) @(negedge clk);
   endtask
   task automatic test_reset_mid_run;
      int c, s;
      set_op(1, 256'd2);
      bus.req_valid = 4'b0010;
      wait_grant(c);
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL mid_grant: got %b want 0010", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      n_cmp++; if (busy !== 1'b0 || core_start !== 1'b0 || bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0) begin n_err++; $display("FAIL mid_async_ctl: got busy=%b start=%b want 0/0", busy, core_start); end
      n_cmp++; if (bus.resp_rx !== '0 || core_px !== '0 || core_d !== '0) begin n_err++; $display("FAIL mid_async_data: got rx=%h px=%h want 0", bus.resp_rx, core_px); end
      set_op(0, 256'd1);
      bus.req_valid = 4'b1111;
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL mid_first_grant: got %b want 0001", bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 4'b0;
      wait_resp(c, s);
      n_cmp++; if (bus.resp_valid !== 4'b0001 || bus.resp_rx !== GX || bus.resp_err !== 1'b0) begin n_err++; $display("FAIL mid_resume: got %b rx=%h", bus.resp_valid, bus.resp_rx); end
      do_ack(4'b0001);
      @(negedge clk);
   endtask
`ifdef ECC_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int c, s;
      hang = 1'b1;
      set_op(1, 256'd2);
      bus.req_valid = 4'b0010;
      wait_grant(c);
      @(negedge clk);
      bus.req_valid = 4'b0;
      wait_resp(c, s);
      n_cmp++; if (c !== 100) begin n_err++; $display("FAIL tmo_latency: got %0d want 100", c); end
      n_cmp++; if (bus.resp_valid !== 4'b0010 || bus.resp_err !== 1'b1) begin n_err++; $display("FAIL tmo_flag: got valid=%b err=%b want 0010/1", bus.resp_valid, bus.resp_err); end
      n_cmp++; if (bus.resp_rx !== '0 || bus.resp_ry !== '0) begin n_err++; $display("FAIL tmo_zero: got rx=%h ry=%h want 0", bus.resp_rx, bus.resp_ry); end
      hang = 1'b0;
      do_ack(4'b0010);
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
   endtask
`endif
   initial begin
      bus.req_valid = 4'b0;
      bus.resp_ack  = 4'b0;
      bus.req_px    = '0;
      bus.req_py    = '0;
      bus.req_m     = '0;
      bus.req_d     = '0;
      test_reset;
      test_single;
      test_contention;
      test_back_to_back;
      test_stale_ready;
      test_reset_mid_run;
`ifdef ECC_ARB_TIMEOUT_EN
      test_timeout;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
